// File: rtl/fpio_sync_fifo.sv
// fpio_sync_fifo
// Single-clock FIFO implementing both ends of the FPIO avail/data/en/ack
// handshake. Storage is a circular buffer of DEPTH = 2**FIFO_BITS - 1 words
// so that both avail buses fit exactly in FIFO_BITS bits. Acks depend only on
// the registered occupancy (no write-to-read bypass), reads are first-word
// fall-through, and protocol misuse is latched in sticky error flags.
module fpio_sync_fifo #(
  parameter int FIFO_BITS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int HI_WM      = 12,
  parameter int LO_WM      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  output logic [FIFO_BITS-1:0]  in_avail,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_en,
  output logic                  in_data_ack,
  output logic [FIFO_BITS-1:0]  out_avail,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_data_en,
  output logic                  out_data_ack,
  output logic                  hi_wm,
  output logic                  lo_wm,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int DEPTH = (1 << FIFO_BITS) - 1;

  localparam logic [FIFO_BITS-1:0] DEPTH_V = FIFO_BITS'(DEPTH);
  localparam logic [FIFO_BITS-1:0] LAST_V  = FIFO_BITS'(DEPTH - 1);
  localparam logic [FIFO_BITS-1:0] HI_V    = FIFO_BITS'(HI_WM);
  localparam logic [FIFO_BITS-1:0] LO_V    = FIFO_BITS'(LO_WM);
  localparam logic [FIFO_BITS-1:0] ZERO_V  = {FIFO_BITS{1'b0}};
  localparam logic [FIFO_BITS-1:0] ONE_V   = {{(FIFO_BITS-1){1'b0}}, 1'b1};

  // Storage is deliberately not reset; its content is only visible while
  // count_r says the slot holds a live word.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [FIFO_BITS-1:0] count_r;
  logic [FIFO_BITS-1:0] wr_ptr_r;
  logic [FIFO_BITS-1:0] rd_ptr_r;
  logic                 err_overflow_r;
  logic                 err_underflow_r;

  logic                 full_s;
  logic                 empty_s;
  logic                 wr_ack_s;
  logic                 rd_ack_s;
  logic [FIFO_BITS-1:0] count_nxt_s;

  // Pointers wrap at DEPTH-1, not at a power of two, because DEPTH is 2**N-1.
  function automatic logic [FIFO_BITS-1:0] ptr_inc(input logic [FIFO_BITS-1:0] ptr);
    logic [FIFO_BITS-1:0] nxt;
    if (ptr == LAST_V) begin
      nxt = ZERO_V;
    end else begin
      nxt = ptr + ONE_V;
    end
    return nxt;
  endfunction

  // Handshake decode: acks come from the current count only; flush blocks both.
  always_comb begin
    full_s   = (count_r == DEPTH_V);
    empty_s  = (count_r == ZERO_V);
    wr_ack_s = in_data_en  & ~full_s  & ~flush;
    rd_ack_s = out_data_en & ~empty_s & ~flush;
  end

  // Next occupancy: a simultaneous read and write leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ack_s, rd_ack_s})
      2'b10:   count_nxt_s = count_r + ONE_V;
      2'b01:   count_nxt_s = count_r - ONE_V;
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state: async reset, then flush, then normal pointer/count/flag update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r         <= ZERO_V;
      wr_ptr_r        <= ZERO_V;
      rd_ptr_r        <= ZERO_V;
      err_overflow_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else if (flush) begin
      count_r         <= ZERO_V;
      wr_ptr_r        <= ZERO_V;
      rd_ptr_r        <= ZERO_V;
      err_overflow_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (wr_ack_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_ack_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (in_data_en && full_s) begin
        err_overflow_r <= 1'b1;
      end
      if (out_data_en && empty_s) begin
        err_underflow_r <= 1'b1;
      end
    end
  end

  // Payload write on an accepted write; readable from the following cycle.
  always_ff @(posedge clock) begin
    if (wr_ack_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Status and data outputs derived from the registered occupancy.
  always_comb begin
    in_data_ack   = wr_ack_s;
    out_data_ack  = rd_ack_s;
    in_avail      = DEPTH_V - count_r;
    out_avail     = count_r;
    hi_wm         = (count_r >= HI_V);
    lo_wm         = (count_r <= LO_V);
    err_overflow  = err_overflow_r;
    err_underflow = err_underflow_r;
    if (empty_s) begin
      out_data = {DATA_WIDTH{1'b0}};
    end else begin
      out_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_fpio_sync_fifo.sv
// Directed testbench for fpio_sync_fifo (FIFO_BITS=4, DEPTH=15).
// Inputs change on the falling edge, outputs are compared 1 time unit later.
module tb_fpio_sync_fifo;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic [3:0]  in_avail;
  logic [31:0] in_data;
  logic        in_data_en;
  logic        in_data_ack;
  logic [3:0]  out_avail;
  logic [31:0] out_data;
  logic        out_data_en;
  logic        out_data_ack;
  logic        hi_wm;
  logic        lo_wm;
  logic        err_overflow;
  logic        err_underflow;

  int n_checks;
  int n_fail;

  logic [31:0] q[$];
  int          occ;
  logic        w_sel;
  logic        r_sel;
  logic [31:0] rnd_data;
  logic [4:0]  avail_sum;

  fpio_sync_fifo #(
    .FIFO_BITS (4),
    .DATA_WIDTH(32),
    .HI_WM     (12),
    .LO_WM     (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_avail     (in_avail),
    .in_data      (in_data),
    .in_data_en   (in_data_en),
    .in_data_ack  (in_data_ack),
    .out_avail    (out_avail),
    .out_data     (out_data),
    .out_data_en  (out_data_en),
    .out_data_ack (out_data_ack),
    .hi_wm        (hi_wm),
    .lo_wm        (lo_wm),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Occupancy-derived status must track the model queue.
  task automatic chk_status(input string tag);
    chk({tag, "_out_avail"}, 64'(out_avail), 64'(q.size()));
    chk({tag, "_in_avail"},  64'(in_avail),  64'(15 - q.size()));
    chk({tag, "_hi_wm"},     64'(hi_wm),     64'(q.size() >= 12));
    chk({tag, "_lo_wm"},     64'(lo_wm),     64'(q.size() <= 2));
  endtask

  task automatic idle();
    @(negedge clock);
    in_data_en  = 1'b0;
    out_data_en = 1'b0;
    flush       = 1'b0;
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clock);
    in_data_en  = 1'b1;
    in_data     = d;
    out_data_en = 1'b0;
    #1;
    chk_status("push");
    chk("push_ack", 64'(in_data_ack), 64'd1);
    q.push_back(d);
  endtask

  task automatic pop();
    @(negedge clock);
    in_data_en  = 1'b0;
    out_data_en = 1'b1;
    #1;
    chk_status("pop");
    chk("pop_ack",  64'(out_data_ack), 64'd1);
    chk("pop_data", 64'(out_data),     64'(q[0]));
    void'(q.pop_front());
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    flush       = 1'b0;
    in_data     = 32'h0;
    in_data_en  = 1'b0;
    out_data_en = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle();
    chk("rst_in_avail",  64'(in_avail),      64'd15);
    chk("rst_out_avail", 64'(out_avail),     64'd0);
    chk("rst_lo_wm",     64'(lo_wm),         64'd1);
    chk("rst_hi_wm",     64'(hi_wm),         64'd0);
    chk("rst_in_ack",    64'(in_data_ack),   64'd0);
    chk("rst_out_ack",   64'(out_data_ack),  64'd0);
    chk("rst_err_ovf",   64'(err_overflow),  64'd0);
    chk("rst_err_unf",   64'(err_underflow), 64'd0);

    // Fill 15 words back-to-back
    for (int i = 0; i < 15; i++) begin
      push(32'h100 + 32'(i));
    end
    idle();
    chk("full_in_avail",  64'(in_avail),  64'd0);
    chk("full_out_avail", 64'(out_avail), 64'd15);
    chk("full_hi_wm",     64'(hi_wm),     64'd1);
    chk("full_err_ovf",   64'(err_overflow), 64'd0);

    // 16th write while full: rejected
    @(negedge clock);
    in_data_en = 1'b1;
    in_data    = 32'h1FF;
    #1;
    chk("ovf_in_ack", 64'(in_data_ack), 64'd0);

    // Full with simultaneous read/write: only the read is acked
    @(negedge clock);
    in_data_en  = 1'b1;
    in_data     = 32'h1FF;
    out_data_en = 1'b1;
    #1;
    chk("ovf_flag",      64'(err_overflow), 64'd1);
    chk("ovf_out_avail", 64'(out_avail),    64'd15);
    chk("fullrw_in_ack", 64'(in_data_ack),  64'd0);
    chk("fullrw_out_ack",64'(out_data_ack), 64'd1);
    chk("fullrw_data",   64'(out_data),     64'h100);
    void'(q.pop_front());
    idle();
    chk("fullrw_count",  64'(out_avail),    64'd14);

    // Drain the rest in order
    for (int i = 0; i < 14; i++) begin
      pop();
    end
    idle();
    chk("drain_out_avail", 64'(out_avail), 64'd0);
    chk("drain_lo_wm",     64'(lo_wm),     64'd1);

    // Empty with simultaneous write/read: only the write is acked
    @(negedge clock);
    in_data_en  = 1'b1;
    in_data     = 32'hAA;
    out_data_en = 1'b1;
    #1;
    chk("emptyrw_in_ack",  64'(in_data_ack),  64'd1);
    chk("emptyrw_out_ack", 64'(out_data_ack), 64'd0);
    q.push_back(32'hAA);
    idle();
    chk("unf_flag",       64'(err_underflow), 64'd1);
    chk("emptyrw_data",   64'(out_data),      64'hAA);
    chk("emptyrw_count",  64'(out_avail),     64'd1);
    pop();

    // Wrap-around: random interleaving at occupancy 5..10
    for (int i = 0; i < 7; i++) begin
      push(32'h200 + 32'(i));
    end
    for (int i = 0; i < 40; i++) begin
      occ = q.size();
      if (occ <= 5) begin
        w_sel = 1'b1;
        r_sel = 1'($urandom_range(0, 1));
      end else if (occ >= 10) begin
        w_sel = 1'($urandom_range(0, 1));
        r_sel = 1'b1;
      end else begin
        w_sel = 1'($urandom_range(0, 1));
        r_sel = 1'($urandom_range(0, 1));
      end
      rnd_data = $urandom;
      @(negedge clock);
      in_data_en  = w_sel;
      in_data     = rnd_data;
      out_data_en = r_sel;
      #1;
      avail_sum = 5'(in_avail) + 5'(out_avail);
      chk("wrap_invariant", 64'(avail_sum),    64'd15);
      chk("wrap_out_avail", 64'(out_avail),    64'(occ));
      chk("wrap_in_ack",    64'(in_data_ack),  64'(w_sel));
      chk("wrap_out_ack",   64'(out_data_ack), 64'(r_sel));
      if (r_sel) begin
        chk("wrap_data", 64'(out_data), 64'(q[0]));
        void'(q.pop_front());
      end
      if (w_sel) begin
        q.push_back(rnd_data);
      end
    end

    // Bring occupancy to 7, then flush with both requests active
    while (q.size() < 7) push(32'h300 + 32'(q.size()));
    while (q.size() > 7) pop();
    @(negedge clock);
    flush       = 1'b1;
    in_data_en  = 1'b1;
    in_data     = 32'h3FF;
    out_data_en = 1'b1;
    #1;
    chk("flush_out_avail_pre", 64'(out_avail),    64'd7);
    chk("flush_in_ack",        64'(in_data_ack),  64'd0);
    chk("flush_out_ack",       64'(out_data_ack), 64'd0);
    q.delete();
    idle();
    chk_status("flush");
    chk("flush_err_ovf", 64'(err_overflow),  64'd0);
    chk("flush_err_unf", 64'(err_underflow), 64'd0);

    // Async reset mid-stream at occupancy 7, with an error flag set
    @(negedge clock);
    out_data_en = 1'b1;
    #1;
    chk("unf2_out_ack", 64'(out_data_ack), 64'd0);
    idle();
    chk("unf2_flag", 64'(err_underflow), 64'd1);
    for (int i = 0; i < 7; i++) begin
      push(32'h400 + 32'(i));
    end
    @(negedge clock);
    in_data_en  = 1'b1;
    in_data     = 32'h4FF;
    out_data_en = 1'b1;
    #1;
    chk("rstmid_out_avail_pre", 64'(out_avail), 64'd7);
    reset_n = 1'b0;
    #1;
    chk("rstmid_async_avail", 64'(out_avail), 64'd0);
    in_data_en  = 1'b0;
    out_data_en = 1'b0;
    #1;
    reset_n = 1'b1;
    q.delete();
    idle();
    chk_status("rstmid");
    chk("rstmid_err_ovf", 64'(err_overflow),  64'd0);
    chk("rstmid_err_unf", 64'(err_underflow), 64'd0);

    // FIFO keeps working after the reset
    push(32'h55);
    pop();
    idle();
    chk_status("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
